// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - state and operand-select encodings shared by the hazard controller
package pipe_hazard_pkg;

  typedef enum logic [1:0] {RUN, PC_DRAIN, MEM_WAIT} hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding selects and stall/flush control for the pipelined RSA CPU
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int RA_W       = 4,
  parameter int PC_REG     = 15,
  parameter int PIPE_DEPTH = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  RA1E,
  input  logic [RA_W-1:0]  RA2E,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [RA_W-1:0]  WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReady,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             DrainErr
);

  localparam int              DW         = $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0]   DRAIN_INIT = DW'(PIPE_DEPTH - 2);
  localparam logic [RA_W-1:0] PC_ADDR    = RA_W'(PC_REG);

  logic          rst_meta, rst_sync;
  hz_state_t     state, state_nxt, ret_state, ret_nxt;
  logic [DW-1:0] drain_cnt, cnt_nxt;
  logic          err_nxt;
  logic          ld_stall;
  fwd_sel_t      fwd_a, fwd_b;

  // Assert immediately, release two clocks after the pin deasserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  function automatic fwd_sel_t fwd_pick(input logic [RA_W-1:0] ra,
                                        input logic we_m, input logic [RA_W-1:0] wa_m,
                                        input logic we_w, input logic [RA_W-1:0] wa_w);
    fwd_pick = FWD_RF;
    if (ra != PC_ADDR) begin
      if (we_m && (wa_m == ra))      fwd_pick = FWD_M;
      else if (we_w && (wa_w == ra)) fwd_pick = FWD_W;
    end
  endfunction

  assign fwd_a     = fwd_pick(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
  assign fwd_b     = fwd_pick(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  assign ForwardAE = rst_sync ? fwd_a : FWD_RF;
  assign ForwardBE = rst_sync ? fwd_b : FWD_RF;

  assign ld_stall = MemtoRegE && (WA3E != PC_ADDR) && ((WA3E == RA1D) || (WA3E == RA2D));

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    cnt_nxt   = drain_cnt;
    err_nxt   = DrainErr;
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0;
    if (!MemReady) begin
      {StallF, StallD, StallE, StallM} = 4'hF;
      state_nxt = MEM_WAIT;
      if (state != MEM_WAIT) ret_nxt = state;
    end else begin
      case (state)
        RUN: begin
          if (BranchTakenE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else begin
            if (ld_stall) begin
              StallF = 1'b1;
              StallD = 1'b1;
              FlushE = 1'b1;
            end
            if (PCSrcD) begin
              state_nxt = PC_DRAIN;
              cnt_nxt   = DRAIN_INIT;
            end
          end
        end
        PC_DRAIN: begin
          // Release the PC in the cycle the write-back supplies the new value.
          StallF = !PCSrcW;
          FlushD = 1'b1;
          if (PCSrcW) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else if (drain_cnt < DW'(2)) begin
            err_nxt   = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = drain_cnt - DW'(1);
          end
        end
        MEM_WAIT: begin
          {StallF, StallD, StallE, StallM} = 4'hF;
          state_nxt = ret_state;
        end
        default: state_nxt = RUN;
      endcase
    end
    if (!rst_sync) begin
      {StallF, StallD, StallE, StallM} = 4'h0;
      FlushD = 1'b0;
      FlushE = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= RUN;
      ret_state <= RUN;
      drain_cnt <= '0;
      DrainErr  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      drain_cnt <= cnt_nxt;
      DrainErr  <= err_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (rst_sync),
    .inc   (StallF),
    .count (StallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (rst_sync),
    .inc   (FlushD | FlushE),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table, corner sequences and random model check of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int DRAIN   = 5 - 2;
  localparam int CNT_MAX = 65535;
  localparam int NV      = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcW, BranchTakenE, MemReady;
  logic [1:0]  ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, DrainErr;
  logic [15:0] StallCount, FlushCount;

  int n_cmp = 0;
  int n_bad = 0;

  int m_drain, m_sc, m_fc;
  bit m_wait, m_err;

  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rwm, rww, m2r, br, mr;
    logic [1:0] fa, fb;
    logic [3:0] stl;
    logic [1:0] fl;
  } vec_t;

  vec_t tbl [NV];

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemReady(MemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .FlushCount(FlushCount), .DrainErr(DrainErr)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  function automatic vec_t mk(int ra1d, int ra2d, int ra1e, int ra2e, int wa3e, int wa3m, int wa3w,
                              int rwm, int rww, int m2r, int br, int mr,
                              int fa, int fb, int stl, int fl);
    vec_t v;
    v.ra1d = 4'(ra1d); v.ra2d = 4'(ra2d); v.ra1e = 4'(ra1e); v.ra2e = 4'(ra2e);
    v.wa3e = 4'(wa3e); v.wa3m = 4'(wa3m); v.wa3w = 4'(wa3w);
    v.rwm = 1'(rwm); v.rww = 1'(rww); v.m2r = 1'(m2r); v.br = 1'(br); v.mr = 1'(mr);
    v.fa = 2'(fa); v.fb = 2'(fb); v.stl = 4'(stl); v.fl = 2'(fl);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; PCSrcD = 0; PCSrcW = 0;
    BranchTakenE = 0; MemReady = 1;
  endtask

  task automatic cyc_chk(input string name, input logic [3:0] stl, input logic [1:0] fl);
    @(negedge clk);
    chk({name, ".stall"}, 64'({StallF, StallD, StallE, StallM}), 64'(stl));
    chk({name, ".flush"}, 64'({FlushD, FlushE}), 64'(fl));
    @(posedge clk); #1;
  endtask

  // Reset is checked while asserted, then released and given time to synchronise.
  task automatic do_reset(input string name);
    reset = 1'b0;
    #1;
    chk({name, ".outs_in_reset"},
        64'({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, DrainErr}), 64'(0));
    chk({name, ".cnts_in_reset"}, 64'({StallCount, FlushCount}), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    m_drain = 0; m_wait = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endtask

  function automatic int ref_fwd(logic [3:0] ra);
    if (ra == 4'd15) return 0;
    if (RegWriteM && WA3M == ra) return 2;
    if (RegWriteW && WA3W == ra) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
  endfunction

  task automatic rand_cycle();
    int ea, eb;
    logic [3:0] es;
    logic [1:0] ef;
    bit ld;
    RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
    WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
    RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
    MemtoRegE = 1'($urandom_range(0, 2) == 0);
    PCSrcD = 1'($urandom_range(0, 7) == 0);
    PCSrcW = 1'($urandom_range(0, 4) == 0);
    BranchTakenE = 1'($urandom_range(0, 7) == 0);
    MemReady = 1'($urandom_range(0, 9) != 0);
    ea = ref_fwd(RA1E);
    eb = ref_fwd(RA2E);
    ld = MemtoRegE && WA3E != 4'd15 && (WA3E == RA1D || WA3E == RA2D);
    es = 4'b0000; ef = 2'b00;
    if (!MemReady || m_wait) es = 4'b1111;
    else if (m_drain > 0) begin es = {!PCSrcW, 3'b000}; ef = 2'b10; end
    else if (BranchTakenE) ef = 2'b11;
    else if (ld) begin es = 4'b1100; ef = 2'b01; end
    @(negedge clk);
    chk("rnd.fa", 64'(ForwardAE), 64'(ea));
    chk("rnd.fb", 64'(ForwardBE), 64'(eb));
    chk("rnd.stall", 64'({StallF, StallD, StallE, StallM}), 64'(es));
    chk("rnd.flush", 64'({FlushD, FlushE}), 64'(ef));
    chk("rnd.scnt", 64'(StallCount), 64'(m_sc));
    chk("rnd.fcnt", 64'(FlushCount), 64'(m_fc));
    chk("rnd.derr", 64'(DrainErr), 64'(m_err));
    if (es[3] && m_sc < CNT_MAX) m_sc++;
    if ((ef != 0) && m_fc < CNT_MAX) m_fc++;
    if (!MemReady) m_wait = 1;
    else if (m_wait) m_wait = 0;
    else if (m_drain > 0) begin
      if (PCSrcW) m_drain = 0;
      else begin
        m_drain--;
        if (m_drain == 0) m_err = 1;
      end
    end else if (PCSrcD && !BranchTakenE) m_drain = DRAIN;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 3, 0, 0, 3, 3,    1, 1, 0, 0, 1, 'b10, 'b00, 'b0000, 'b00);
    tbl[1]  = mk(0, 0, 15, 15, 0, 15, 15, 1, 1, 0, 0, 1, 'b00, 'b00, 'b0000, 'b00);
    tbl[2]  = mk(0, 0, 5, 5, 0, 0, 5,    0, 1, 0, 0, 1, 'b01, 'b01, 'b0000, 'b00);
    tbl[3]  = mk(0, 0, 7, 2, 0, 2, 7,    1, 1, 0, 0, 1, 'b01, 'b10, 'b0000, 'b00);
    tbl[4]  = mk(0, 0, 4, 4, 0, 4, 4,    0, 0, 0, 0, 1, 'b00, 'b00, 'b0000, 'b00);
    tbl[5]  = mk(0, 2, 0, 0, 2, 0, 0,    0, 0, 1, 0, 1, 'b00, 'b00, 'b1100, 'b01);
    tbl[6]  = mk(15, 0, 0, 0, 15, 0, 0,  0, 0, 1, 0, 1, 'b00, 'b00, 'b0000, 'b00);
    tbl[7]  = mk(6, 0, 0, 0, 6, 0, 0,    0, 0, 1, 1, 1, 'b00, 'b00, 'b0000, 'b11);
    tbl[8]  = mk(6, 0, 0, 0, 6, 0, 0,    0, 0, 0, 0, 1, 'b00, 'b00, 'b0000, 'b00);
    tbl[9]  = mk(6, 0, 0, 0, 6, 0, 0,    0, 0, 1, 1, 0, 'b00, 'b00, 'b1111, 'b00);
    tbl[10] = mk(0, 0, 0, 9, 0, 9, 9,    1, 1, 0, 0, 1, 'b00, 'b10, 'b0000, 'b00);
    tbl[11] = mk(0, 0, 0, 15, 0, 0, 15,  0, 1, 0, 0, 1, 'b00, 'b00, 'b0000, 'b00);

    idle();
    #2;
    do_reset("init");

    for (int i = 0; i < NV; i++) begin
      idle();
      RA1D = tbl[i].ra1d; RA2D = tbl[i].ra2d; RA1E = tbl[i].ra1e; RA2E = tbl[i].ra2e;
      WA3E = tbl[i].wa3e; WA3M = tbl[i].wa3m; WA3W = tbl[i].wa3w;
      RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww; MemtoRegE = tbl[i].m2r;
      BranchTakenE = tbl[i].br; MemReady = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d.fa", i), 64'(ForwardAE), 64'(tbl[i].fa));
      chk($sformatf("vec%0d.fb", i), 64'(ForwardBE), 64'(tbl[i].fb));
      chk($sformatf("vec%0d.stall", i), 64'({StallF, StallD, StallE, StallM}), 64'(tbl[i].stl));
      chk($sformatf("vec%0d.flush", i), 64'({FlushD, FlushE}), 64'(tbl[i].fl));
      @(posedge clk); #1;
      idle();
      repeat (2) @(posedge clk);
      #1;
    end

    // Single load-use bubble.
    do_reset("ld");
    MemtoRegE = 1; WA3E = 2; RA2D = 2;
    cyc_chk("ld0", 4'b1100, 2'b01);
    idle();
    cyc_chk("ld1", 4'b0000, 2'b00);
    chk("ld.scnt", 64'(StallCount), 64'(1));
    chk("ld.fcnt", 64'(FlushCount), 64'(1));

    // PC write drained and completed by write-back.
    do_reset("pc");
    PCSrcD = 1;
    cyc_chk("pc0", 4'b0000, 2'b00);
    idle();
    cyc_chk("pc1", 4'b1000, 2'b10);
    cyc_chk("pc2", 4'b1000, 2'b10);
    PCSrcW = 1;
    cyc_chk("pc3", 4'b0000, 2'b10);
    idle();
    MemtoRegE = 1; WA3E = 2; RA2D = 2;
    cyc_chk("pc4", 4'b1100, 2'b01);
    chk("pc.derr", 64'(DrainErr), 64'(0));

    // Drain watchdog expiry is sticky.
    do_reset("wd");
    PCSrcD = 1;
    cyc_chk("wd0", 4'b0000, 2'b00);
    idle();
    cyc_chk("wd1", 4'b1000, 2'b10);
    cyc_chk("wd2", 4'b1000, 2'b10);
    chk("wd.derr_early", 64'(DrainErr), 64'(0));
    cyc_chk("wd3", 4'b1000, 2'b10);
    chk("wd.derr_set", 64'(DrainErr), 64'(1));
    cyc_chk("wd4", 4'b0000, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    chk("wd.derr_sticky", 64'(DrainErr), 64'(1));

    // Memory wait in the middle of a drain freezes the watchdog.
    do_reset("mw");
    PCSrcD = 1;
    cyc_chk("mw0", 4'b0000, 2'b00);
    idle();
    cyc_chk("mw1", 4'b1000, 2'b10);
    MemReady = 0;
    for (int k = 0; k < 4; k++) cyc_chk($sformatf("mw_wait%0d", k), 4'b1111, 2'b00);
    MemReady = 1;
    cyc_chk("mw_ready", 4'b1111, 2'b00);
    cyc_chk("mw_resume", 4'b1000, 2'b10);
    PCSrcW = 1;
    cyc_chk("mw_done", 4'b0000, 2'b10);
    idle();
    chk("mw.derr", 64'(DrainErr), 64'(0));
    cyc_chk("mw_run", 4'b0000, 2'b00);

    // Random traffic against the reference model.
    do_reset("rnd");
    for (int k = 0; k < 2000; k++) rand_cycle();

    // Stall counter saturation, then asynchronous reset mid-run.
    do_reset("sat");
    MemReady = 0;
    repeat (65536 + 5) @(posedge clk);
    #1;
    chk("sat.scnt", 64'(StallCount), 64'(CNT_MAX));
    chk("sat.fcnt", 64'(FlushCount), 64'(0));
    RegWriteM = 1; WA3M = 3; RA1E = 3;
    #2;
    do_reset("midrst");
    MemtoRegE = 1; WA3E = 2; RA2D = 2;
    cyc_chk("midrst_run", 4'b1100, 2'b01);
    chk("midrst.scnt", 64'(StallCount), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
